conv1d_stream: RTL and testbench
================================

# conv1d_stream

Parametrised streaming 1-D FIR convolution engine: the generalised successor of the fixed 3-tap weighted convolution sequencer. It accepts a packet of samples over a valid/ready stream, convolves it with a run-time loadable TAPS-coefficient kernel, and emits a saturated, scaled result stream with packet framing. It supports both "full" mode (zero-padded, L+TAPS-1 outputs) and "valid" mode (L-TAPS+1 outputs), and sits between the line buffer and the post-processing stage.

## Interface
- DATA_W, 8, unsigned input sample width
- COEF_W, 8, unsigned coefficient width
- TAPS, 3, kernel length (≥2)
- OUT_W, 8, output width
- SHIFT, 0, right shift applied to accumulator before saturation
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset; clk is the single clock
- coef_we  in  1  coefficient write strobe (honoured only in IDLE)
- coef_idx  in  $clog2(TAPS)  coefficient index; idx ≥ TAPS ignored
- coef_data  in  COEF_W  coefficient value
- mode  in  1  0 = full, 1 = valid; sampled on first accepted sample of a packet
- s_valid / s_ready  in/out  1  input handshake
- s_data  in  DATA_W  input sample
- s_last  in  1  marks final sample of packet
- m_valid / m_ready  out/in  1  output handshake
- m_data  out  OUT_W  result
- m_last  out  1  marks final result of packet
- err_short  out  1  one-cycle pulse: valid-mode packet shorter than TAPS

## Operation
- Window register w[0..TAPS-1] (w[0] newest); cleared to zero at reset and at every packet start.
- Each accepted input (or flush zero) shifts the window: w[0] ← sample, w[k] ← w[k-1].
- y = Σ h[k]·w[k] after the shift, accumulator width ACC_W = DATA_W+COEF_W+$clog2(TAPS), no overflow.
- m_data = min(y >> SHIFT, 2^OUT_W − 1) (unsigned saturation).
- Coefficients h[k] reset to h[0]=1, others 0 (identity). Writes outside IDLE are dropped.
- FSM states:
  - IDLE: s_ready=1 (subject to output stall); the first accept latches mode, clears the window, and enters RUN (or straight to FLUSH/IDLE if s_last is also set).
  - RUN: accepts samples; on accepting s_last → FLUSH (full mode, TAPS-1 > 0) or IDLE (valid mode).
  - FLUSH: s_ready=0; injects TAPS-1 zero samples, one per cycle whenever the output slot is free; after the last one → IDLE.
- Full mode: every shift produces an output; L inputs → L+TAPS-1 outputs; m_last on the final flush output.
- Valid mode: outputs are suppressed for the first TAPS-1 shifts of a packet; m_last accompanies the output of the s_last sample.
- Valid-mode packet with L < TAPS: no output is emitted, err_short pulses the cycle after s_last is accepted, and the FSM returns to IDLE.

## Timing
- Single output register: s_ready = (state≠FLUSH) && (!m_valid || m_ready).
- Latency: result appears on m_data/m_valid the cycle after the shift that produced it.
- Throughput: one sample per cycle with m_ready held high, including back-to-back packets (IDLE accept in the cycle after the last flush output).
- m_valid, m_data, m_last stay stable while m_valid && !m_ready.
- A coef_we in the same cycle as the first accept of a packet is dropped; the new packet uses the old kernel.
- Reset values: s_ready=0 while rst is low, 1 after release; m_valid=0, m_data=0, m_last=0, err_short=0, state=IDLE, window=0, coefficients at their reset values.
- Reset asserted mid-packet aborts the packet immediately; no partial m_last is produced.

## Test plan
- TAPS=3, h=(1,2,2), mode=0, x=(1,2,3, last on 3), m_ready=1 → outputs 1,4,9,10,6; m_last only on 6; s_ready low for 2 flush cycles.
- Same kernel, mode=1, x=(1,2,3) → single output 9 with m_last; x=(4,5) in valid mode → no output, err_short pulse.
- h=(255,255,255), x=(255,255,255), SHIFT=0, mode=1 → output 255 (saturated, raw 195075); with SHIFT=10, OUT_W=8 → 190.
- Backpressure: m_ready toggling 1,0,0,1 during the full-mode packet above → identical sequence 1,4,9,10,6, no loss or duplicate, data held while stalled.
- Coefficient write during RUN (idx 0 ← 7) ignored; rewritten in IDLE → next packet x=(1) full mode yields 7,2,2.
- rst pulled low after two samples, released, then x=(3, last) full mode with h reset → outputs 3,0,0 (identity kernel, clean window).

Source files
------------

// File: rtl/conv1d_stream.sv
// Streaming 1-D FIR convolution: packetised valid/ready input, run-time kernel,
// full (zero-padded) or valid mode, scaled and saturated single-register output.
module conv1d_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 3,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      coef_we_i,
  input  logic [$clog2(TAPS)-1:0]   coef_idx_i,
  input  logic [COEF_W-1:0]         coef_data_i,
  input  logic                      mode_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [DATA_W-1:0]         s_data_i,
  input  logic                      s_last_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [OUT_W-1:0]          m_data_o,
  output logic                      m_last_o,
  output logic                      err_short_o
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int CNT_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic [DATA_W-1:0]   win_q [TAPS];
  logic [DATA_W-1:0]   win_d [TAPS];
  logic [COEF_W-1:0]   coef_q [TAPS];
  logic [COEF_W-1:0]   coef_d [TAPS];
  logic                m_valid_q, m_valid_d;
  logic [OUT_W-1:0]    m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic                err_q, err_d;

  logic                slot_free;
  logic                accept;
  logic                do_shift;
  logic                mode_eff;
  logic [CNT_W-1:0]    cnt_base;
  logic [CNT_W-1:0]    cnt_n;
  logic [DATA_W-1:0]   in_sample;
  logic [DATA_W-1:0]   win_n [TAPS];
  logic [ACC_W-1:0]    acc;
  logic                produce;
  logic                last_out;

  function automatic logic [OUT_W-1:0] sat_scale(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] sh;
    sh = a >> SHIFT;
    if ((sh >> OUT_W) != '0) return '1;
    return sh[OUT_W-1:0];
  endfunction

  // Handshake, window shift and accumulation
  always_comb begin
    slot_free = !m_valid_q || m_ready_i;
    s_ready_o = rst_n_i && (state_q != FLUSH) && slot_free;
    accept    = s_valid_i && s_ready_o;
    do_shift  = accept || ((state_q == FLUSH) && slot_free);
    mode_eff  = (state_q == IDLE) ? mode_i : mode_q;
    cnt_base  = (state_q == IDLE) ? '0 : cnt_q;
    cnt_n     = (cnt_base < CNT_W'(TAPS)) ? cnt_base + CNT_W'(1) : cnt_base;
    in_sample = (state_q == FLUSH) ? '0 : s_data_i;

    // A new packet starts from an all-zero window.
    win_n[0] = in_sample;
    for (int k = 1; k < TAPS; k++) begin
      win_n[k] = (state_q == IDLE) ? '0 : win_q[k-1];
    end

    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + ACC_W'(win_n[k]) * ACC_W'(coef_q[k]);
    end

    produce  = 1'b0;
    last_out = 1'b0;
    if (state_q == FLUSH) begin
      produce  = slot_free;
      last_out = (fcnt_q == CNT_W'(TAPS - 2));
    end else if (accept) begin
      produce  = !mode_eff || (cnt_n >= CNT_W'(TAPS));
      last_out = mode_eff && s_last_i && (cnt_n >= CNT_W'(TAPS));
    end
  end

  // Next-state, kernel and output register logic
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    err_d     = accept && s_last_i && mode_eff && (cnt_n < CNT_W'(TAPS));
    for (int k = 0; k < TAPS; k++) begin
      win_d[k]  = do_shift ? win_n[k] : win_q[k];
      coef_d[k] = coef_q[k];
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = mode_i;
          cnt_d   = cnt_n;
          fcnt_d  = '0;
          state_d = s_last_i ? (mode_i ? IDLE : FLUSH) : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d  = cnt_n;
          fcnt_d = '0;
          if (s_last_i) state_d = mode_q ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          fcnt_d = fcnt_q + CNT_W'(1);
          if (fcnt_q == CNT_W'(TAPS - 2)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The kernel may only change between packets, never on a packet's first accept.
    if (coef_we_i && (state_q == IDLE) && !accept) begin
      for (int k = 0; k < TAPS; k++) begin
        if (int'(coef_idx_i) == k) coef_d[k] = coef_data_i;
      end
    end

    if (slot_free) begin
      m_valid_d = produce;
      m_last_d  = produce && last_out;
      if (produce) m_data_d = sat_scale(acc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= (k == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k]  <= win_d[k];
        coef_q[k] <= coef_d[k];
      end
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign m_last_o    = m_last_q;
  assign err_short_o = err_q;

endmodule

// File: tb/tb_conv1d_stream.sv
// Bench for conv1d_stream: directed scenarios plus randomized packets against a
// direct-convolution reference, run on SHIFT=0 and SHIFT=10 instances in lockstep.
module tb_conv1d_stream;
  localparam int TAPS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coef_we = 1'b0;
  logic [1:0] coef_idx = '0;
  logic [7:0] coef_data = '0;
  logic       mode = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b1;

  logic       s_ready_a, m_valid_a, m_last_a, err_a;
  logic [7:0] m_data_a;
  logic       s_ready_b, m_valid_b, m_last_b, err_b;
  logic [7:0] m_data_b;

  always #5 clk = ~clk;

  conv1d_stream #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8), .SHIFT(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .coef_we_i(coef_we), .coef_idx_i(coef_idx),
    .coef_data_i(coef_data), .mode_i(mode), .s_valid_i(s_valid), .s_ready_o(s_ready_a),
    .s_data_i(s_data), .s_last_i(s_last), .m_valid_o(m_valid_a), .m_ready_i(m_ready),
    .m_data_o(m_data_a), .m_last_o(m_last_a), .err_short_o(err_a));

  conv1d_stream #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8), .SHIFT(10)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .coef_we_i(coef_we), .coef_idx_i(coef_idx),
    .coef_data_i(coef_data), .mode_i(mode), .s_valid_i(s_valid), .s_ready_o(s_ready_b),
    .s_data_i(s_data), .s_last_i(s_last), .m_valid_o(m_valid_b), .m_ready_i(m_ready),
    .m_data_o(m_data_b), .m_last_o(m_last_b), .err_short_o(err_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int hm [TAPS];
  int pkt_x [$];
  int q_a [$];
  int q_b [$];
  bit q_l [$];
  bit mon_en = 1'b0;

  function automatic int sat8(longint y, int sh);
    longint v;
    v = y >>> sh;
    return (v > 255) ? 255 : int'(v);
  endfunction

  // Expected results straight from the convolution sum y[n] = sum h[k]*x[n-k].
  function automatic void model_push(bit md);
    int L;
    L = pkt_x.size();
    for (int n = 0; n <= L + TAPS - 2; n++) begin
      longint y;
      y = 0;
      for (int k = 0; k < TAPS; k++)
        if (n - k >= 0 && n - k < L) y += longint'(hm[k]) * pkt_x[n-k];
      if (!md || (n >= TAPS - 1 && n <= L - 1)) begin
        q_a.push_back(sat8(y, 0));
        q_b.push_back(sat8(y, 10));
        q_l.push_back(md ? (n == L - 1) : (n == L + TAPS - 2));
      end
    end
  endfunction

  int bp_mode = 0;
  int bp_i = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: begin m_ready = pat[bp_i % 4]; bp_i++; end
    endcase
  end

  // Output must match the head of the expected queue every cycle it is valid, stalled or not.
  always @(negedge clk) begin
    if (mon_en && rst_n && m_valid_a) begin
      if (q_a.size() == 0) begin
        chk("unexpected_out", m_valid_a, 0);
      end else begin
        chk("m_data", m_data_a, q_a[0]);
        chk("m_last", m_last_a, q_l[0]);
        chk("m_valid_s10", m_valid_b, 1);
        chk("m_data_s10", m_data_b, q_b[0]);
        chk("m_last_s10", m_last_b, q_l[0]);
        if (m_ready) begin
          void'(q_a.pop_front());
          void'(q_b.pop_front());
          void'(q_l.pop_front());
        end
      end
    end
  end

  task automatic load_coef(input int idx, input int val);
    coef_we   = 1'b1;
    coef_idx  = 2'(idx);
    coef_data = 8'(val);
    @(posedge clk);
    #1 coef_we = 1'b0;
    if (idx < TAPS) hm[idx] = val;
  endtask

  task automatic send_packet(input bit md, input int we_at, input int we_idx, input int we_val);
    int L;
    L = pkt_x.size();
    model_push(md);
    for (int i = 0; i < L; i++) begin
      int t;
      t = 0;
      @(negedge clk);
      s_valid   = 1'b1;
      s_data    = 8'(pkt_x[i]);
      s_last    = (i == L - 1);
      mode      = md;
      coef_we   = (i == we_at);
      coef_idx  = 2'(we_idx);
      coef_data = 8'(we_val);
      while (!s_ready_a && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("accept_timeout", s_ready_a, 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      coef_we = 1'b0;
    end
    @(negedge clk);
    chk("err_short", err_a, (md && L < TAPS) ? 1 : 0);
    chk("err_short_s10", err_b, (md && L < TAPS) ? 1 : 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_a.size() != 0 || m_valid_a) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", q_a.size(), 0);
  endtask

  task automatic set_pkt3(input int a, input int b, input int c, input int n);
    pkt_x.delete();
    if (n > 0) pkt_x.push_back(a);
    if (n > 1) pkt_x.push_back(b);
    if (n > 2) pkt_x.push_back(c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hm = '{1, 0, 0};

    // Reset state
    @(negedge clk);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_m_last", m_last_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_s_ready", s_ready_a, 1);
    mon_en = 1'b1;

    load_coef(0, 1);
    load_coef(1, 2);
    load_coef(2, 2);
    load_coef(3, 99);

    // Full mode, no backpressure, flush leaves s_ready low for two cycles
    set_pkt3(1, 2, 3, 3);
    send_packet(1'b0, -1, 0, 0);
    chk("flush_ready_0", s_ready_a, 0);
    @(negedge clk);
    chk("flush_ready_1", s_ready_a, 0);
    @(negedge clk);
    chk("flush_ready_end", s_ready_a, 1);
    drain();

    set_pkt3(1, 2, 3, 3);
    send_packet(1'b1, -1, 0, 0);
    drain();
    set_pkt3(4, 5, 0, 2);
    send_packet(1'b1, -1, 0, 0);
    drain();

    bp_mode = 2;
    set_pkt3(1, 2, 3, 3);
    send_packet(1'b0, -1, 0, 0);
    drain();
    bp_mode = 0;
    @(negedge clk);

    // Kernel writes during RUN or on a first accept are dropped
    set_pkt3(1, 2, 3, 3);
    send_packet(1'b0, 1, 0, 7);
    drain();
    set_pkt3(1, 0, 0, 1);
    send_packet(1'b0, 0, 0, 7);
    drain();
    load_coef(0, 7);
    set_pkt3(1, 0, 0, 1);
    send_packet(1'b0, -1, 0, 0);
    drain();

    for (int k = 0; k < TAPS; k++) load_coef(k, 255);
    set_pkt3(255, 255, 255, 3);
    send_packet(1'b1, -1, 0, 0);
    drain();

    bp_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int L;
      if ($urandom_range(0, 3) == 0) begin
        drain();
        for (int k = 0; k < TAPS; k++)
          load_coef(k, $urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(0, 3));
      end
      pkt_x.delete();
      L = $urandom_range(1, 6);
      for (int i = 0; i < L; i++) pkt_x.push_back($urandom_range(0, 255));
      send_packet(1'(($urandom_range(0, 1))), -1, 0, 0);
    end
    drain();
    bp_mode = 0;

    // Reset in the middle of a packet
    mon_en = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'd1;
    s_last  = 1'b0;
    mode    = 1'b0;
    @(posedge clk);
    #1 s_data = 8'd2;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", s_ready_a, 0);
    chk("midrst_m_valid", m_valid_a, 0);
    chk("midrst_m_data", m_data_a, 0);
    chk("midrst_m_last", m_last_a, 0);
    chk("midrst_m_valid_s10", m_valid_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_release_ready", s_ready_a, 1);
    q_a.delete();
    q_b.delete();
    q_l.delete();
    hm = '{1, 0, 0};
    mon_en = 1'b1;
    set_pkt3(3, 0, 0, 1);
    send_packet(1'b0, -1, 0, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
